// File: rtl/round_timer_ctrl.sv
// Game round sequencer: phase code, per-round seconds countdown, answer scoring and round stepping.
// Optional pause input and paused phase code (1101) are enabled by defining ROUND_PAUSE_EN.
module round_timer_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int COUNT_START  = 10,
  parameter int NUM_ROUNDS   = 5,
  parameter int RESULT_TICKS = 2,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               answer_valid_i,
  input  logic               answer_correct_i,
`ifdef ROUND_PAUSE_EN
  input  logic               pause_i,
`endif
  output logic [3:0]         state_code_o,
  output logic [3:0]         digit_o,
  output logic [3:0]         round_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               timeout_o,
  output logic               game_over_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
  localparam int SW = (SCORE_W > 4) ? SCORE_W : 4;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RES_MAX  = RW'(RESULT_TICKS - 1);
  localparam logic [SW:0]   SCORE_MAX = (SW+1)'({SCORE_W{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_COUNT, S_RESULT, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [RW-1:0]        res_cnt_q, res_cnt_d;
  logic [3:0]           digit_q, digit_d;
  logic [3:0]           round_q, round_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 timeout_q, timeout_d;
  logic                 game_over_q, game_over_d;
  logic [3:0]           code_q, code_d;
  logic                 paused;
  logic                 tick;
  logic [SW:0]          sum;

`ifdef ROUND_PAUSE_EN
  assign paused = pause_i && (state_q == S_COUNT);
`else
  assign paused = 1'b0;
`endif

  assign tick = (((state_q == S_COUNT) && !paused) || (state_q == S_RESULT))
                && (tick_cnt_q == TICK_MAX);
  // Widened so a narrow score can still absorb a full 4-bit digit before saturating.
  assign sum  = (SW+1)'(score_q) + (SW+1)'(digit_q);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = '0;
    res_cnt_d  = res_cnt_q;
    digit_d    = digit_q;
    round_d    = round_q;
    score_d    = score_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_ARM;
          score_d = '0;
          round_d = 4'd1;
        end
      end
      S_ARM: begin
        digit_d = 4'(COUNT_START);
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (paused) begin
          tick_cnt_d = tick_cnt_q;
        end else begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
          // An answer beats a same-cycle expiry and scores the pre-decrement digit.
          if (answer_valid_i) begin
            state_d    = S_RESULT;
            tick_cnt_d = '0;
            res_cnt_d  = '0;
            if (answer_correct_i)
              score_d = (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];
          end else if (tick) begin
            if (digit_q == 4'd0) begin
              timeout_d  = 1'b1;
              state_d    = S_RESULT;
              tick_cnt_d = '0;
              res_cnt_d  = '0;
            end else begin
              digit_d = digit_q - 4'd1;
            end
          end
        end
      end
      S_RESULT: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (tick) begin
          if (res_cnt_q == RES_MAX) begin
            if (round_q == 4'(NUM_ROUNDS)) begin
              state_d = S_DONE;
            end else begin
              round_d = round_q + 4'd1;
              state_d = S_ARM;
            end
          end else begin
            res_cnt_d = res_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    code_d      = 4'b0000;
    game_over_d = (state_d == S_DONE);
    case (state_d)
      S_ARM:    code_d = 4'b1010;
`ifdef ROUND_PAUSE_EN
      S_COUNT:  code_d = pause_i ? 4'b1101 : 4'b1011;
`else
      S_COUNT:  code_d = 4'b1011;
`endif
      S_RESULT: code_d = 4'b1100;
      S_DONE:   code_d = 4'b1111;
      default:  code_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      res_cnt_q   <= '0;
      digit_q     <= '0;
      round_q     <= '0;
      score_q     <= '0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
      code_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      res_cnt_q   <= res_cnt_d;
      digit_q     <= digit_d;
      round_q     <= round_d;
      score_q     <= score_d;
      timeout_q   <= timeout_d;
      game_over_q <= game_over_d;
      code_q      <= code_d;
    end
  end

  assign state_code_o = code_q;
  assign digit_o      = digit_q;
  assign round_o      = round_q;
  assign score_o      = score_q;
  assign timeout_o    = timeout_q;
  assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl: directed and randomized games against a
// round-level model (countdown offsets and scores computed arithmetically).
module tb_round_timer_ctrl;
  localparam int TICK_DIV     = 4;
  localparam int COUNT_START  = 3;
  localparam int NUM_ROUNDS   = 2;
  localparam int RESULT_TICKS = 1;
  localparam int SCORE_W      = 2;
  localparam int EXPIRE_C     = (COUNT_START + 1) * TICK_DIV - 1;
  localparam int RESULT_LEN   = RESULT_TICKS * TICK_DIV;
  localparam int SMAX         = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               answer_valid = 1'b0;
  logic               answer_correct = 1'b0;
  logic [3:0]         state_code;
  logic [3:0]         digit;
  logic [3:0]         round;
  logic [SCORE_W-1:0] score;
  logic               timeout;
  logic               game_over;

  int n_cmp = 0;
  int n_err = 0;
  int exp_score = 0;
  int exp_round = 0;

  round_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .COUNT_START(COUNT_START), .NUM_ROUNDS(NUM_ROUNDS),
    .RESULT_TICKS(RESULT_TICKS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .answer_valid_i(answer_valid),
    .answer_correct_i(answer_correct),
`ifdef ROUND_PAUSE_EN
    .pause_i(1'b0),
`endif
    .state_code_o(state_code),
    .digit_o(digit),
    .round_o(round),
    .score_o(score),
    .timeout_o(timeout),
    .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"}, state_code, 0);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_gameover"}, game_over, 0);
  endtask

  // Called from IDLE or DONE; leaves the DUT in ARM.
  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_score = 0;
    exp_round = 1;
    chk("start_arm_code", state_code, 4'b1010);
    chk("start_round", round, exp_round);
    chk("start_score", score, exp_score);
    $display("start game: code=%b round=%0d score=%0d", state_code, round, score);
  endtask

  // kind: 0 no answer, 1 correct, 2 wrong; c_ans = COUNT cycle offset of the answer strobe.
  // Called in ARM; returns in the following ARM or DONE.
  task automatic play_round(input int kind, input int c_ans);
    int last_c;
    int model_digit;
    int held;
    held = COUNT_START;
    chk("arm_round", round, exp_round);
    step();
    chk("count_code", state_code, 4'b1011);
    chk("count_start_digit", digit, COUNT_START);
    last_c = (kind == 0) ? EXPIRE_C : c_ans;
    for (int c = 0; c <= last_c; c++) begin
      model_digit = COUNT_START - c / TICK_DIV;
      chk("count_digit", digit, model_digit);
      chk("count_timeout_low", timeout, 0);
      start = ($urandom_range(0, 1) == 1);
      answer_correct = ($urandom_range(0, 1) == 1);
      if (c == last_c && kind != 0) begin
        answer_valid = 1'b1;
        answer_correct = (kind == 1);
        if (kind == 1) exp_score = (exp_score + model_digit > SMAX) ? SMAX : exp_score + model_digit;
      end
      held = model_digit;
      step();
      answer_valid = 1'b0;
      start = 1'b0;
    end
    chk("result_code", state_code, 4'b1100);
    chk("result_timeout", timeout, (kind == 0) ? 1 : 0);
    chk("result_score", score, exp_score);
    chk("result_digit_hold", digit, held);
    $display("round %0d kind=%0d offset=%0d: digit=%0d score=%0d timeout=%0d",
             exp_round, kind, last_c, digit, score, timeout);
    for (int r = 0; r < RESULT_LEN - 1; r++) begin
      answer_valid = ($urandom_range(0, 1) == 1);
      answer_correct = 1'b1;
      start = ($urandom_range(0, 1) == 1);
      step();
      answer_valid = 1'b0;
      start = 1'b0;
      chk("result_hold_code", state_code, 4'b1100);
      chk("result_hold_score", score, exp_score);
      chk("result_timeout_low", timeout, 0);
    end
    step();
    if (exp_round == NUM_ROUNDS) begin
      chk("done_code", state_code, 4'b1111);
      chk("done_gameover", game_over, 1);
      chk("done_score", score, exp_score);
    end else begin
      exp_round++;
      chk("next_arm_code", state_code, 4'b1010);
      chk("next_round", round, exp_round);
      chk("next_gameover", game_over, 0);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    $display("reset: code=%b digit=%0d round=%0d score=%0d", state_code, digit, round, score);

    // Answer strobe in IDLE is ignored
    answer_valid = 1'b1;
    answer_correct = 1'b1;
    step();
    answer_valid = 1'b0;
    step();
    chk("idle_answer_code", state_code, 4'b0000);
    chk("idle_answer_score", score, 0);
    $display("idle answer: code=%b score=%0d", state_code, score);

    // Game 1: timeout round, then correct answer while digit=2
    start_game();
    play_round(0, 0);
    play_round(1, TICK_DIV);
    chk("game1_score", score, 2);

    // Answer in DONE is ignored
    answer_valid = 1'b1;
    answer_correct = 1'b1;
    step();
    answer_valid = 1'b0;
    chk("done_answer_score", score, 2);
    chk("done_answer_code", state_code, 4'b1111);
    $display("done answer: code=%b score=%0d", state_code, score);

    // Game 2: answer on the expiry tick (digit 0), then answer at digit=COUNT_START
    start_game();
    play_round(1, EXPIRE_C);
    play_round(1, 0);

    // Game 3: score saturation
    start_game();
    play_round(1, 0);
    play_round(1, TICK_DIV);
    chk("sat_score", score, SMAX);

    // Randomized games
    for (int g = 0; g < 6; g++) begin
      start_game();
      for (int r = 0; r < NUM_ROUNDS; r++)
        play_round(int'($urandom_range(0, 2)), int'($urandom_range(0, EXPIRE_C)));
    end

    // Reset mid-COUNT clears everything asynchronously
    start_game();
    step();
    repeat (5) step();
    chk("precut_code", state_code, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    $display("async reset mid-count: code=%b digit=%0d round=%0d", state_code, digit, round);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_code", state_code, 4'b0000);
    chk("post_reset_score", score, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
